// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and defaults for the memory-request arbiter.
// Requester slot numbering and state encoding live here.
package mem_arb_pkg;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_TIMEOUT = 64;

  localparam int REQ_IFETCH = 0;
  localparam int REQ_DATA   = 1;
  localparam int REQ_DMA    = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    ISSUE   = 3'b010,
    RELEASE = 3'b100
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and interpreter-side bus of the memory-request arbiter.
// slave = arbiter view, master = environment (requesters + interpreter) view.
interface mem_req_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) ();

  localparam int IW = idx_w(NUM_REQ);

  logic [NUM_REQ*32-1:0] r_addr;
  logic [NUM_REQ*32-1:0] r_wdata;
  logic [NUM_REQ-1:0]    r_ren;
  logic [NUM_REQ-1:0]    r_wen;
  logic [NUM_REQ-1:0]    r_ack;
  logic [NUM_REQ-1:0]    r_err;
  logic [31:0]           r_rdata;
  logic [31:0]           m_addr;
  logic [31:0]           m_wdata;
  logic                  m_ren;
  logic                  m_wen;
  logic                  m_ack;
  logic [31:0]           m_rdata;
  logic                  busy;
  logic [IW-1:0]         grant_id;

  modport slave (
    input  r_addr, r_wdata, r_ren, r_wen, m_ack, m_rdata,
    output r_ack, r_err, r_rdata, m_addr, m_wdata, m_ren, m_wen, busy, grant_id
  );

  modport master (
    output r_addr, r_wdata, r_ren, r_wen, m_ack, m_rdata,
    input  r_ack, r_err, r_rdata, m_addr, m_wdata, m_ren, m_wen, busy, grant_id
  );

endinterface

// File: rtl/mem_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request after last_grant,
// wrapping modulo NUM_REQ.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [idx_w(NUM_REQ)-1:0]  last_grant,
  output logic                       valid,
  output logic [idx_w(NUM_REQ)-1:0]  index
);

  localparam int          IW = idx_w(NUM_REQ);
  localparam int unsigned N  = NUM_REQ;

  logic [IW-1:0] slot;

  always_comb begin
    valid = 1'b0;
    index = '0;
    slot  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      slot = IW'((32'(last_grant) + k) % N);
      if (!valid && req[slot]) begin
        valid = 1'b1;
        index = slot;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one four-phase memory port among NUM_REQ requesters,
// with one-cycle completion pulses and a timeout abort for accesses never acked.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  mem_req_arbiter_if.slave bus
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                   state;
  logic [IW-1:0]            last_grant;
  logic [IW-1:0]            grant_q;
  logic [CW-1:0]            cnt;
  logic [NUM_REQ-1:0]       req;
  logic                     pick_valid;
  logic [IW-1:0]            pick_idx;
  logic [NUM_REQ-1:0][31:0] addr_arr;
  logic [NUM_REQ-1:0][31:0] wdata_arr;

  logic [31:0]              m_addr_q;
  logic [31:0]              m_wdata_q;
  logic                     m_ren_q;
  logic                     m_wen_q;
  logic [NUM_REQ-1:0]       r_ack_q;
  logic [NUM_REQ-1:0]       r_err_q;
  logic [31:0]              r_rdata_q;

  assign req       = bus.r_ren | bus.r_wen;
  assign addr_arr  = bus.r_addr;
  assign wdata_arr = bus.r_wdata;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      grant_q    <= '0;
      cnt        <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_ren_q    <= 1'b0;
      m_wen_q    <= 1'b0;
      r_ack_q    <= '0;
      r_err_q    <= '0;
      r_rdata_q  <= '0;
    end else begin
      r_ack_q   <= '0;
      r_err_q   <= '0;
      r_rdata_q <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            m_addr_q   <= addr_arr[pick_idx];
            m_wdata_q  <= wdata_arr[pick_idx];
            // A requester raising both strobes is served as a read.
            m_ren_q    <= bus.r_ren[pick_idx];
            m_wen_q    <= ~bus.r_ren[pick_idx];
            grant_q    <= pick_idx;
            last_grant <= pick_idx;
            cnt        <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.m_ack) begin
            r_ack_q[grant_q] <= 1'b1;
            r_rdata_q        <= m_ren_q ? bus.m_rdata : '0;
            m_ren_q          <= 1'b0;
            m_wen_q          <= 1'b0;
            state            <= RELEASE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            r_ack_q[grant_q] <= 1'b1;
            r_err_q[grant_q] <= 1'b1;
            m_ren_q          <= 1'b0;
            m_wen_q          <= 1'b0;
            state            <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!bus.m_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_ren    = m_ren_q;
  assign bus.m_wen    = m_wen_q;
  assign bus.r_ack    = r_ack_q;
  assign bus.r_err    = r_err_q;
  assign bus.r_rdata  = r_rdata_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
Shares the single memory-request port of the address interpreter (addr/data_i/ren/wen in, ack/data_o out) between NUM_REQ requesters, e.g. instruction fetch, data access and DMA.
- Grants round-robin.
- Registers and holds the granted command downstream.
- Follows the downstream four-phase handshake, in which ack stays high until ren/wen fall.
- Returns one-cycle ack/rdata pulses to the requester.
- A timeout aborts accesses that never ack, such as unmapped writes, and reports an error.

Parameters:
NUM_REQ, 3, number of requesters; index 0 = ifetch, 1 = data, 2 = DMA.
TIMEOUT, 64, cycles in ISSUE without m_ack before abort; must be >= 2.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  reset; synchronous, active-high.
r_addr  in  NUM_REQ*32  per-requester address; slice i = [32*i+31:32*i].
r_wdata  in  NUM_REQ*32  per-requester write data.
r_ren  in  NUM_REQ  read request, level; held until own r_ack.
r_wen  in  NUM_REQ  write request, level; held until own r_ack.
r_ack  out  NUM_REQ  one-cycle completion pulse to requester i.
r_err  out  NUM_REQ  high with r_ack when the access timed out.
r_rdata  out  32  read data; shared bus, valid only during an r_ack pulse.
m_addr  out  32  to interpreter addr.
m_wdata  out  32  to interpreter data_i.
m_ren  out  1  to interpreter ren.
m_wen  out  1  to interpreter wen.
m_ack  in  1  from interpreter ack.
m_rdata  in  32  from interpreter data_o.
busy  out  1  high whenever state != IDLE.
grant_id  out  $clog2(NUM_REQ)  index of current or last grant.

Behaviour:
- **Reset:** all outputs 0. state=IDLE. last_grant=NUM_REQ-1, so requester 0 wins the first tie. Applies in any state, including mid-access; the interpreter is reset by the same rst.
- **Request per requester:** req_i = r_ren[i] | r_wen[i]. If both are high, it is treated as a read and r_wen is ignored.
- **States:** IDLE, ISSUE, RELEASE; one-hot, all registered.
- **IDLE:**
  - If any req_i, pick the first asserted index scanning last_grant+1, +2, ... modulo NUM_REQ.
  - Next cycle: m_addr/m_wdata latch that requester's addr/wdata. m_ren or m_wen goes 1. grant_id and last_grant update. state goes to ISSUE.
  - No request: stay in IDLE, outputs unchanged apart from strobes = 0.
- **ISSUE:** hold m_* stable and count cycles from 0.
  - **m_ack=1:**
    - Next cycle: r_ack[grant]=1, r_err=0. r_rdata=m_rdata for a read, 0 for a write.
    - m_ren/m_wen drop to 0; state goes to RELEASE.
  - **count reaches TIMEOUT-1 with no ack:**
    - Next cycle: r_ack[grant]=1, r_err[grant]=1, r_rdata=0.
    - Strobes drop; state goes to RELEASE.
- **RELEASE:** strobes stay 0, requests are not sampled. Go to IDLE on the first cycle m_ack=0. Minimum 1 cycle; the interpreter drops ack one cycle after seeing ren/wen low.
- **Requester side:**
  - r_ack and r_err clear after one cycle.
  - The requester must drop its request by the cycle after its r_ack. RELEASE plus IDLE sampling gives it that cycle, so a completed request is never re-granted.
  - A requester that keeps its request asserted is re-served, but only after the others in round-robin order.
- **Issue latency:** request visible in IDLE at cycle N gives m_ren=1 at N+1. m_ack rising at cycle K gives r_ack at K+1. Minimum turnaround between grants is 3 cycles (ISSUE, RELEASE, IDLE).
- **Simultaneous events:**
  - A new request arriving during ISSUE/RELEASE waits.
  - m_ack and timeout in the same cycle: ack wins, r_err=0.
  - An unexpected m_ack in IDLE is ignored.
- **Fairness:** with all NUM_REQ requesting continuously, every requester is granted once per NUM_REQ grants.

Decomposition:
- **Package mem_arb_pkg:**
  - state enum: IDLE, ISSUE, RELEASE.
  - requester index constants: REQ_IFETCH=0, REQ_DATA=1, REQ_DMA=2.
  - default NUM_REQ and TIMEOUT.
- **Sub-module rr_pick:** combinational round-robin selector.
  - Inputs: req vector, last_grant.
  - Outputs: valid, index.
- **Top level** holds the FSM, timeout counter, and command/response registers.

Test Plan:
1. Single read: requester 1, r_addr=32'h1FC0_0010, model acks 3 cycles after m_ren with m_rdata=32'hDEAD_BEEF -> m_ren at N+1, r_ack[1] 1 cycle after m_ack with r_rdata=32'hDEAD_BEEF, r_err=0, busy returns 0 after m_ack falls.
2. Write: requester 2, addr 32'h0000_0100, wdata 32'h1234_5678 -> m_wen=1, m_wdata=32'h1234_5678 held stable until ack; r_ack[2] pulse with r_rdata=0.
3. All three requesting continuously from reset -> grant order 0, 1, 2, 0, 1, 2; never two consecutive grants to one index while others wait.
4. Model never acks (unmapped write), TIMEOUT=8 -> after 8 ISSUE cycles r_ack=1 and r_err=1 for one cycle, m_wen drops, next request is served normally.
5. Both r_ren and r_wen high on requester 0 -> only m_ren asserted; read data returned.
6. rst asserted mid-ISSUE -> next cycle all outputs 0, state IDLE; after release, requester 0 is granted first.
